// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes and the BIST sequencer state encoding.
package axil_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_FINISH
    } bist_state_t;

endpackage

// File: rtl/axil_ram_bist.sv
// AXI4-Lite master that fills a RAM window with seed^index and optionally
// reads it back, counting bad responses and data miscompares.
module axil_ram_bist
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int BASE_ADDR  = 0,
    parameter int WORD_COUNT = 2 ** (ADDR_WIDTH - $clog2(STRB_WIDTH))
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    localparam int CW = $clog2(WORD_COUNT + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WORD_COUNT - 1);

    bist_state_t           r_state;
    logic                  r_mode;
    logic [DATA_WIDTH-1:0] r_seed;
    logic [CW-1:0]         r_idx;
    logic                  r_awvalid, r_wvalid, r_aw_done, r_w_done;
    logic                  r_bready, r_arvalid, r_rready;
    logic                  r_busy, r_done, r_pass;
    logic [15:0]           r_err;

    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_pattern;
    logic                  w_bhit, w_rhit, w_err_inc, w_last, w_aw_ok, w_w_ok;
    logic [15:0]           w_err_next;

    // Address and pattern derive from the registered index, so they stay stable while valid.
    assign w_addr    = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(r_idx) * ADDR_WIDTH'(STRB_WIDTH);
    assign w_pattern = r_seed ^ DATA_WIDTH'(r_idx);
    assign w_bhit    = m_axil_bvalid && r_bready;
    assign w_rhit    = m_axil_rvalid && r_rready;
    assign w_err_inc = (w_bhit && (m_axil_bresp != AXI_RESP_OKAY)) ||
                       (w_rhit && ((m_axil_rresp != AXI_RESP_OKAY) || (m_axil_rdata != w_pattern)));
    assign w_err_next = (w_err_inc && (r_err != 16'hFFFF)) ? r_err + 16'd1 : r_err;
    assign w_last    = (r_idx == LAST_IDX);
    assign w_aw_ok   = r_aw_done || (r_awvalid && m_axil_awready);
    assign w_w_ok    = r_w_done  || (r_wvalid  && m_axil_wready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_mode    <= 1'b0;
            r_seed    <= '0;
            r_idx     <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_err     <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= w_err_next;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_WR_REQ;
                        r_mode    <= mode;
                        r_seed    <= seed;
                        r_idx     <= '0;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_busy    <= 1'b1;
                        r_pass    <= 1'b0;
                        r_err     <= '0;
                    end
                end
                ST_WR_REQ: begin
                    // AW and W retire independently; the response phase waits for both.
                    if (r_awvalid && m_axil_awready) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (r_wvalid && m_axil_wready) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_ok && w_w_ok) begin
                        r_state  <= ST_WR_RESP;
                        r_bready <= 1'b1;
                    end
                end
                ST_WR_RESP: begin
                    if (w_bhit) begin
                        r_bready <= 1'b0;
                        if (!w_last) begin
                            r_idx     <= r_idx + 1'b1;
                            r_state   <= ST_WR_REQ;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                        end else if (r_mode) begin
                            r_idx     <= '0;
                            r_state   <= ST_RD_REQ;
                            r_arvalid <= 1'b1;
                        end else begin
                            r_state <= ST_FINISH;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_pass  <= (w_err_next == 16'd0);
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (r_arvalid && m_axil_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_RESP;
                    end
                end
                ST_RD_RESP: begin
                    if (w_rhit) begin
                        r_rready <= 1'b0;
                        if (!w_last) begin
                            r_idx     <= r_idx + 1'b1;
                            r_state   <= ST_RD_REQ;
                            r_arvalid <= 1'b1;
                        end else begin
                            r_state <= ST_FINISH;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_pass  <= (w_err_next == 16'd0);
                        end
                    end
                end
                ST_FINISH: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err;
    assign m_axil_awaddr  = r_awvalid ? w_addr : '0;
    assign m_axil_awvalid = r_awvalid;
    assign m_axil_wdata   = r_wvalid ? w_pattern : '0;
    assign m_axil_wstrb   = r_wvalid ? {STRB_WIDTH{1'b1}} : '0;
    assign m_axil_wvalid  = r_wvalid;
    assign m_axil_bready  = r_bready;
    assign m_axil_araddr  = r_arvalid ? w_addr : '0;
    assign m_axil_arvalid = r_arvalid;
    assign m_axil_rready  = r_rready;

endmodule

// File: tb/tb_axil_ram_bist.sv
// Bench for axil_ram_bist against a small behavioural AXI4-Lite RAM slave
// with injectable ready skew, write-response errors and read-data corruption.
module tb_axil_ram_bist;
    import axil_pkg::*;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int SW = 4;
    localparam int NW = 64;

    logic          clk = 1'b0;
    logic          rst, start, mode;
    logic [DW-1:0] seed;
    logic          busy, done, pass;
    logic [15:0]   err_count;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    bresp, rresp;

    always #5 clk = ~clk;

    axil_ram_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW),
                    .BASE_ADDR(0), .WORD_COUNT(NW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .m_axil_awaddr(awaddr), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid),
        .m_axil_wready(wready), .m_axil_bresp(bresp), .m_axil_bvalid(bvalid),
        .m_axil_bready(bready), .m_axil_araddr(araddr), .m_axil_arvalid(arvalid),
        .m_axil_arready(arready), .m_axil_rdata(rdata), .m_axil_rresp(rresp),
        .m_axil_rvalid(rvalid), .m_axil_rready(rready)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- slave model ----------------
    logic [DW-1:0] mem [NW];
    logic          s_aw_have = 1'b0, s_w_have = 1'b0;
    logic [AW-1:0] s_aw_addr;
    logic [DW-1:0] s_w_data;
    int            s_aw_cnt = 0, s_aw_tgt = 0, s_w_cnt = 0, s_w_tgt = 0;
    logic          s_commit = 1'b0;
    logic [AW-1:0] s_c_addr;
    logic [DW-1:0] s_c_data;
    int            n_aw = 0, n_w = 0, n_ar = 0, n_b = 0;
    logic          skew_en = 1'b0;
    int            bad_wr = -1;
    logic [NW-1:0] cor = '0;

    always @(posedge clk) begin
        s_commit <= 1'b0;
        if (rst) begin
            awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
            arready <= 1'b0; rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
            s_aw_have <= 1'b0; s_w_have <= 1'b0;
            s_aw_cnt <= 0; s_w_cnt <= 0; s_aw_tgt <= 0; s_w_tgt <= 0;
        end else begin
            if (awready && awvalid) begin
                awready <= 1'b0; s_aw_have <= 1'b1; s_aw_addr <= awaddr; n_aw <= n_aw + 1;
            end else if (awvalid && !s_aw_have && !awready) begin
                if (s_aw_cnt >= s_aw_tgt) awready <= 1'b1;
                else s_aw_cnt <= s_aw_cnt + 1;
            end
            if (wready && wvalid) begin
                wready <= 1'b0; s_w_have <= 1'b1; s_w_data <= wdata; n_w <= n_w + 1;
            end else if (wvalid && !s_w_have && !wready) begin
                if (s_w_cnt >= s_w_tgt) wready <= 1'b1;
                else s_w_cnt <= s_w_cnt + 1;
            end
            if (s_aw_have && s_w_have && !bvalid) begin
                mem[s_aw_addr[AW-1:2]] <= s_w_data;
                bvalid   <= 1'b1;
                bresp    <= (int'(s_aw_addr[AW-1:2]) == bad_wr) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                s_aw_have <= 1'b0; s_w_have <= 1'b0;
                s_commit <= 1'b1; s_c_addr <= s_aw_addr; s_c_data <= s_w_data;
                s_aw_cnt <= 0; s_w_cnt <= 0;
                s_aw_tgt <= skew_en ? int'($urandom_range(5, 0)) : 0;
                s_w_tgt  <= skew_en ? int'($urandom_range(5, 0)) : 0;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0; n_b <= n_b + 1;
            end
            if (arready && arvalid) begin
                arready <= 1'b0; rvalid <= 1'b1; rresp <= AXI_RESP_OKAY; n_ar <= n_ar + 1;
                rdata <= mem[araddr[AW-1:2]] ^ {31'b0, cor[araddr[AW-1:2]]};
            end else if (arvalid && !arready && !rvalid) begin
                arready <= 1'b1;
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    logic [39:0] exp_wr_q [$];
    logic [7:0]  exp_rd_q [$];
    logic [16:0] exp_res_q [$];

    logic          p_rst = 1'b1, p_awv = 1'b0, p_awr = 1'b0, p_wv = 1'b0, p_wr = 1'b0;
    logic [AW-1:0] p_awaddr;
    logic [DW-1:0] p_wdata;

    always @(negedge clk) begin : monitor
        logic [39:0] ew;
        logic [7:0]  er;
        logic [16:0] eres;
        if (!rst) begin
            if (s_commit) begin
                if (exp_wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    ew = exp_wr_q.pop_front();
                    chk("wr_addr", s_c_addr, ew[39:32]);
                    chk("wr_data", s_c_data, ew[31:0]);
                end
            end
            if (arvalid && arready) begin
                if (exp_rd_q.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    er = exp_rd_q.pop_front();
                    chk("rd_addr", araddr, er);
                end
            end
            if (done) begin
                if (exp_res_q.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    eres = exp_res_q.pop_front();
                    chk("done_pass", pass, eres[16]);
                    chk("done_errs", err_count, eres[15:0]);
                    chk("done_busy", busy, 0);
                end
            end
            if (!p_rst && p_awv && !p_awr) chk("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
            if (!p_rst && p_wv && !p_wr)   chk("w_hold", {wvalid, wdata}, {1'b1, p_wdata});
            if (wvalid)  chk("wstrb", wstrb, 4'hF);
            if (arvalid) chk("rd_wr_excl", {awvalid, wvalid, bready}, 3'b000);
        end
        p_rst = rst; p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
        p_wv = wvalid; p_wr = wready; p_wdata = wdata;
    end

    task automatic push_run(bit m, logic [31:0] s, bit ps, logic [15:0] ec);
        for (int k = 0; k < NW; k++) begin
            exp_wr_q.push_back({8'(k * 4), s ^ 32'(k)});
            if (m) exp_rd_q.push_back(8'(k * 4));
        end
        exp_res_q.push_back({ps, ec});
    endtask

    task automatic go(bit m, logic [31:0] s);
        @(negedge clk);
        mode = m; seed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_errclr", err_count, 0);
        chk("start_passclr", pass, 0);
    endtask

    task automatic wait_done(string nm);
        int n;
        n = 0;
        while (!done && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk(nm, 0, 1);
    endtask

    int b_aw, b_w, b_ar, b_b;
    task automatic snap();
        b_aw = n_aw; b_w = n_w; b_ar = n_ar; b_b = n_b;
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; mode = 1'b0; seed = '0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {busy, done, pass, awvalid, wvalid, bready, arvalid, rready}, 8'h00);
        chk("rst_err", err_count, 0);
        rst = 1'b0;

        // 1: fill only, seed 0
        snap(); push_run(0, 32'h0, 1, 16'd0);
        go(0, 32'h0); wait_done("r1_timeout");
        chk("r1_mem5", mem[5], 32'h0000_0005);
        chk("r1_ar", n_ar - b_ar, 0);
        chk("r1_aw", n_aw - b_aw, 64);
        chk("r1_w", n_w - b_w, 64);

        // 2: fill and verify
        snap(); push_run(1, 32'hA5A5_0000, 1, 16'd0);
        go(1, 32'hA5A5_0000); wait_done("r2_timeout");
        chk("r2_mem63", mem[63], 32'hA5A5_003F);
        chk("r2_ar", n_ar - b_ar, 64);
        chk("r2_pass", pass, 1);

        // 3: read data corrupted on words 3 and 7
        cor[3] = 1'b1; cor[7] = 1'b1;
        snap(); push_run(1, 32'h0F0F_0F0F, 0, 16'd2);
        go(1, 32'h0F0F_0F0F); wait_done("r3_timeout");
        chk("r3_xfers", (n_aw - b_aw) + (n_ar - b_ar), 128);
        chk("r3_err", err_count, 2);
        cor = '0;

        // 4: ready skew plus one SLVERR write response
        skew_en = 1'b1; bad_wr = 10;
        snap(); push_run(0, 32'h1111_0000, 0, 16'd1);
        go(0, 32'h1111_0000); wait_done("r4_timeout");
        chk("r4_aw", n_aw - b_aw, 64);
        chk("r4_w", n_w - b_w, 64);
        chk("r4_b", n_b - b_b, 64);
        chk("r4_err", err_count, 1);
        bad_wr = -1;

        // 5: starts while busy and coincident with done are ignored
        snap(); push_run(0, 32'h0000_0001, 1, 16'd0);
        go(0, 32'h0000_0001);
        repeat (20) @(negedge clk);
        mode = 1'b1; seed = 32'hFFFF_FFFF; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done("r5_timeout");
        start = 1'b1; mode = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("r5_nostart", busy, 0);
        repeat (3) @(negedge clk);
        chk("r5_idle", busy, 0);
        chk("r5_ar", n_ar - b_ar, 0);
        chk("r5_aw", n_aw - b_aw, 64);
        skew_en = 1'b0;

        // 6: reset during a read response, then a clean run
        push_run(1, 32'h1234_5678, 1, 16'd0);
        go(1, 32'h1234_5678);
        n = 0;
        while (!rready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("r6_reach_rd", rready, 1);
        rst = 1'b1;
        exp_wr_q.delete(); exp_rd_q.delete(); exp_res_q.delete();
        @(negedge clk);
        chk("r6_rst_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        chk("r6_rst_stat", {busy, done, pass}, 3'b0);
        chk("r6_rst_err", err_count, 0);
        rst = 1'b0;
        snap(); push_run(1, 32'hDEAD_BEEF, 1, 16'd0);
        go(1, 32'hDEAD_BEEF); wait_done("r6_timeout");
        chk("r6_pass", pass, 1);
        chk("r6_ar", n_ar - b_ar, 64);

        repeat (5) @(negedge clk);
        chk("q_wr_empty", exp_wr_q.size(), 0);
        chk("q_rd_empty", exp_rd_q.size(), 0);
        chk("q_res_empty", exp_res_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
